// File: rtl/fetch_defs_pkg.sv
// Shared definitions for the instruction-fetch stage: NOP encoding,
// fetch FSM states and the entry layouts of the two internal queues.
package fetch_defs_pkg;

  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] NOP_INSTR = 32'h0000_0013;

  // HALT is only reachable when FETCH_ALIGN_CHECK_EN is defined
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

  // Instruction buffer entry: fetched word together with its PC
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     data;
  } buf_entry_t;

  // Pending-request entry: PC of the request and the epoch it was issued in
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            epoch;
  } pend_entry_t;

  // Drop the byte-offset bits so a target always addresses a whole word
  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with occupancy count and single-cycle flush.
// The head entry is read straight from the storage array, so the head
// reflects only registered state.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr_reg];
  assign count   = count_reg;

  // Storage write port; contents need no reset because count gates validity
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  // Pointer and occupancy bookkeeping; flush empties the FIFO in one edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues in-order word reads with
// credit-based flow control, buffers returned words and hands them to
// decode. Jumps flush everything and refetch from the target; stale
// responses are recognised by a one-bit epoch tag.
// Optional feature macro FETCH_ALIGN_CHECK_EN: a misaligned jump target
// raises fetch_fault and halts fetching until an aligned jump arrives.
module fetch_unit
  import fetch_defs_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc4,
  output logic        fetch_fault
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t state_reg;
  logic [31:0]  fetch_pc_reg;
  logic         epoch_reg;

  buf_entry_t   buf_head;
  logic [CW-1:0] buf_count;
  logic         buf_empty;
  pend_entry_t  pend_head;
  logic [CW-1:0] pend_count;
  logic         pend_empty;

  logic [CW:0]  in_flight;
  logic         credit;
  logic         accept;
  logic         rsp_pop;
  logic         rsp_keep;
  logic         consume;
  logic [31:0]  redirect_target;

  // Words buffered plus words still in memory never exceed DEPTH, so
  // neither queue can overflow.
  assign in_flight      = {1'b0, buf_count} + {1'b0, pend_count};
  assign credit         = in_flight < (CW + 1)'(DEPTH);
  assign imem_req_valid = (state_reg == ST_RUN) && !redirect && credit;
  assign imem_req_addr  = fetch_pc_reg;
  assign accept         = imem_req_valid && imem_req_ready;

  // A response with no pending entry (e.g. arriving after reset) is ignored
  assign rsp_pop  = imem_rsp_valid && !pend_empty;
  assign rsp_keep = rsp_pop && (pend_head.epoch == epoch_reg) && !redirect;

  assign instr_valid = !buf_empty;
  assign consume     = instr_valid && instr_ready;
  assign instr       = instr_valid ? buf_head.data : NOP_INSTR;
  assign instr_pc    = instr_valid ? buf_head.pc : 32'h0;
  assign instr_pc4   = instr_valid ? (buf_head.pc + 32'd4) : 32'h0;

`ifdef FETCH_ALIGN_CHECK_EN
  assign redirect_target = redirect_pc;
`else
  assign redirect_target = word_align(redirect_pc);
`endif

  fetch_fifo #(.WIDTH($bits(pend_entry_t)), .DEPTH(DEPTH)) u_pend (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .push      (accept),
    .push_data ({fetch_pc_reg, epoch_reg}),
    .pop       (rsp_pop),
    .head      (pend_head),
    .count     (pend_count),
    .empty     (pend_empty)
  );

  fetch_fifo #(.WIDTH($bits(buf_entry_t)), .DEPTH(DEPTH)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (rsp_keep),
    .push_data ({pend_head.pc, imem_rsp_data}),
    .pop       (consume),
    .head      (buf_head),
    .count     (buf_count),
    .empty     (buf_empty)
  );

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_reg;
  assign fetch_fault = fault_reg;

  // Fetch FSM with alignment check: misaligned targets park the unit in HALT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_BOOT;
      fetch_pc_reg <= RESET_PC;
      epoch_reg    <= 1'b0;
      fault_reg    <= 1'b0;
    end else if (redirect) begin
      fetch_pc_reg <= redirect_target;
      epoch_reg    <= ~epoch_reg;
      if (is_aligned(redirect_target)) begin
        state_reg <= ST_RUN;
        fault_reg <= 1'b0;
      end else begin
        state_reg <= ST_HALT;
        fault_reg <= 1'b1;
      end
    end else begin
      if (state_reg == ST_BOOT) state_reg <= ST_RUN;
      if (accept) fetch_pc_reg <= fetch_pc_reg + 32'd4;
    end
  end

  function automatic logic is_aligned(input logic [31:0] a);
    return a[1:0] == 2'b00;
  endfunction
`else
  assign fetch_fault = 1'b0;

  // Fetch FSM: one idle BOOT cycle, then RUN; jumps retarget PC and bump epoch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_BOOT;
      fetch_pc_reg <= RESET_PC;
      epoch_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_BOOT: state_reg <= ST_RUN;
        default: state_reg <= ST_RUN;
      endcase
      if (redirect) begin
        fetch_pc_reg <= redirect_target;
        epoch_reg    <= ~epoch_reg;
      end else if (accept) begin
        fetch_pc_reg <= fetch_pc_reg + 32'd4;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. A behavioural instruction memory with
// configurable latency answers requests; a scoreboard queue receives the
// expected {pc, word} for every accepted request (from the bench's own PC
// model) and is popped whenever decode consumes an instruction.
// Build with FETCH_ALIGN_CHECK_EN defined to exercise the alignment feature.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk, rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc, instr_pc4;
  logic        fetch_fault;

  fetch_unit #(.RESET_PC(RST_PC), .DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_pc4      (instr_pc4),
    .fetch_fault    (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int due; logic [31:0] addr; } mem_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
  typedef struct { logic [31:0] epc, edata, apc, adata, apc4; bit unexp; } pair_t;

  mem_t        mem_q[$];
  exp_t        exp_q[$];
  pair_t       pair_q[$];
  logic [31:0] req_log[$];

  int          cyc, lat, outst, chk_cnt, pass_cnt;
  bit          rdy_rand, ir_want, auto_redir, st_req_valid, st_redirect;
  logic [31:0] auto_pc, model_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'd3) ^ 32'hC0DE_0000;
  endfunction

  // One clock: drive inputs at negedge, observe 1 time unit later
  task automatic step(input bit redir, input logic [31:0] rpc);
    pair_t p;
    @(negedge clk);
    instr_ready    = ir_want;
    imem_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
      outst--;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
    redirect    = redir || (auto_redir && imem_rsp_valid && instr_valid && instr_ready);
    redirect_pc = redir ? rpc : auto_pc;
    #1;
    st_req_valid = imem_req_valid;
    st_redirect  = redirect;
    if (redirect) begin
      exp_q.delete();
      model_pc   = redirect_pc & ~32'h3;
      auto_redir = 1'b0;
    end else if (instr_valid && instr_ready) begin
      p.apc = instr_pc; p.adata = instr; p.apc4 = instr_pc4;
      if (exp_q.size() == 0) begin
        p.unexp = 1'b1; p.epc = 32'h0; p.edata = 32'h0;
      end else begin
        p.unexp = 1'b0; p.epc = exp_q[0].pc; p.edata = exp_q[0].data;
        void'(exp_q.pop_front());
      end
      pair_q.push_back(p);
    end
    if (imem_req_valid && imem_req_ready) begin
      mem_q.push_back('{cyc + lat, imem_req_addr});
      exp_q.push_back('{model_pc, mem_word(model_pc)});
      model_pc = model_pc + 32'd4;
      req_log.push_back(imem_req_addr);
      outst++;
    end
    cyc++;
  endtask

  task automatic assert_reset();
    rst = 1'b1;
    redirect = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    instr_ready = 1'b0;
    mem_q.delete(); exp_q.delete(); pair_q.delete(); req_log.delete();
    outst = 0; model_pc = RST_PC; auto_redir = 1'b0; rdy_rand = 1'b0;
    lat = 1; ir_want = 1'b1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    assert_reset();
    release_reset();
  endtask

  task automatic test_reset();
    do_reset();
    ir_want = 1'b0;
    repeat (4) step(1'b0, 32'h0);
    #2;
    assert_reset();
    #1;
    chk_cnt++; if (imem_req_valid !== 1'b0) $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); else pass_cnt++;
    chk_cnt++; if (instr_valid !== 1'b0) $display("FAIL rst_instr_valid: got %b want 0", instr_valid); else pass_cnt++;
    chk_cnt++; if (instr !== NOP) $display("FAIL rst_instr: got %h want %h", instr, NOP); else pass_cnt++;
    chk_cnt++; if (instr_pc !== 32'h0) $display("FAIL rst_instr_pc: got %h want 0", instr_pc); else pass_cnt++;
    chk_cnt++; if (instr_pc4 !== 32'h0) $display("FAIL rst_instr_pc4: got %h want 0", instr_pc4); else pass_cnt++;
    chk_cnt++; if (fetch_fault !== 1'b0) $display("FAIL rst_fault: got %b want 0", fetch_fault); else pass_cnt++;
    release_reset();
    #1;
    chk_cnt++; if (imem_req_valid !== 1'b0) $display("FAIL boot_req_valid: got %b want 0", imem_req_valid); else pass_cnt++;
    step(1'b0, 32'h0);
    chk_cnt++; if (st_req_valid !== 1'b1 || req_log.size() == 0 || req_log[0] !== RST_PC)
      $display("FAIL first_req: got valid=%b n=%0d want valid=1 addr=%h", st_req_valid, req_log.size(), RST_PC); else pass_cnt++;
    chk_cnt++; if (instr_valid !== 1'b0 || instr !== NOP) $display("FAIL pre_valid_nop: got valid=%b instr=%h want 0/%h", instr_valid, instr, NOP); else pass_cnt++;
    repeat (10) step(1'b0, 32'h0);
    chk_cnt++; if (pair_q.size() < 3 || pair_q[0].apc !== RST_PC || pair_q[0].apc4 !== 32'h104 || pair_q[2].apc !== 32'h108)
      $display("FAIL first_beats: got n=%0d pc0=%h pc4_0=%h want pc0=100 pc4=104 pc2=108", pair_q.size(), pair_q.size() > 0 ? pair_q[0].apc : 32'h0, pair_q.size() > 0 ? pair_q[0].apc4 : 32'h0); else pass_cnt++;
    foreach (pair_q[i]) begin
      chk_cnt++;
      if (pair_q[i].unexp || {pair_q[i].apc, pair_q[i].adata, pair_q[i].apc4} !== {pair_q[i].epc, pair_q[i].edata, pair_q[i].epc + 32'd4})
        $display("FAIL reset_stream[%0d]: got pc=%h instr=%h pc4=%h want pc=%h instr=%h", i, pair_q[i].apc, pair_q[i].adata, pair_q[i].apc4, pair_q[i].epc, pair_q[i].edata);
      else begin pass_cnt++; $display("reset   consume pc=%h instr=%h", pair_q[i].apc, pair_q[i].adata); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    ir_want = 1'b0;
    repeat (10) step(1'b0, 32'h0);
    chk_cnt++; if (req_log.size() > 2 || st_req_valid !== 1'b0)
      $display("FAIL stall_credit: got reqs=%0d valid=%b want <=2 and 0", req_log.size(), st_req_valid); else pass_cnt++;
    ir_want = 1'b1;
    repeat (10) step(1'b0, 32'h0);
    chk_cnt++; if (pair_q.size() < 3 || pair_q[0].apc !== 32'h100 || pair_q[1].apc !== 32'h104 || pair_q[2].apc !== 32'h108)
      $display("FAIL stall_resume: got n=%0d want pcs 100,104,108", pair_q.size()); else pass_cnt++;
    foreach (pair_q[i]) begin
      chk_cnt++;
      if (pair_q[i].unexp || {pair_q[i].apc, pair_q[i].adata, pair_q[i].apc4} !== {pair_q[i].epc, pair_q[i].edata, pair_q[i].epc + 32'd4})
        $display("FAIL stall_stream[%0d]: got pc=%h instr=%h pc4=%h want pc=%h instr=%h", i, pair_q[i].apc, pair_q[i].adata, pair_q[i].apc4, pair_q[i].epc, pair_q[i].edata);
      else begin pass_cnt++; $display("stall   consume pc=%h instr=%h", pair_q[i].apc, pair_q[i].adata); end
    end
  endtask

  task automatic test_redirect();
    int n0, stale;
    bit found;
    do_reset();
    lat = 3;
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      step(1'b0, 32'h0);
      if (req_log.size() >= 4 && outst == 2) found = 1'b1;
    end
    chk_cnt++; if (!found) $display("FAIL redir_setup: got reqs=%0d outst=%0d want 4/2", req_log.size(), outst); else pass_cnt++;
    step(1'b1, 32'h200);
    chk_cnt++; if (st_req_valid !== 1'b0) $display("FAIL redir_no_req: got %b want 0", st_req_valid); else pass_cnt++;
    n0 = pair_q.size();
    step(1'b0, 32'h0);
    chk_cnt++; if (instr_valid !== 1'b0) $display("FAIL redir_flush: got %b want 0", instr_valid); else pass_cnt++;
    repeat (25) step(1'b0, 32'h0);
    chk_cnt++; if (pair_q.size() <= n0 || pair_q[n0].apc !== 32'h200)
      $display("FAIL redir_target: got n=%0d want first pc 200", pair_q.size() - n0); else pass_cnt++;
    stale = 0;
    for (int i = n0; i < pair_q.size(); i++)
      if (pair_q[i].apc == 32'h108 || pair_q[i].apc == 32'h10C) stale++;
    chk_cnt++; if (stale != 0) $display("FAIL redir_stale: got %0d stale want 0", stale); else pass_cnt++;
    foreach (pair_q[i]) begin
      chk_cnt++;
      if (pair_q[i].unexp || {pair_q[i].apc, pair_q[i].adata, pair_q[i].apc4} !== {pair_q[i].epc, pair_q[i].edata, pair_q[i].epc + 32'd4})
        $display("FAIL redir_stream[%0d]: got pc=%h instr=%h pc4=%h want pc=%h instr=%h", i, pair_q[i].apc, pair_q[i].adata, pair_q[i].apc4, pair_q[i].epc, pair_q[i].edata);
      else begin pass_cnt++; $display("redir   consume pc=%h instr=%h", pair_q[i].apc, pair_q[i].adata); end
    end
  endtask

  task automatic test_random();
    int n0;
    bit fired;
    do_reset();
    lat = 2; rdy_rand = 1'b1;
    repeat (20) step(1'b0, 32'h0);
    auto_pc = 32'h300; auto_redir = 1'b1;
    fired = 1'b0;
    for (int k = 0; k < 300 && !fired; k++) begin
      step(1'b0, 32'h0);
      fired = st_redirect;
    end
    chk_cnt++; if (!fired) $display("FAIL rand_coincide: got no coinciding redirect want one"); else pass_cnt++;
    chk_cnt++; if (st_req_valid !== 1'b0) $display("FAIL rand_no_req: got %b want 0", st_req_valid); else pass_cnt++;
    auto_redir = 1'b0;
    n0 = pair_q.size();
    step(1'b0, 32'h0);
    chk_cnt++; if (instr_valid !== 1'b0) $display("FAIL rand_flush: got %b want 0", instr_valid); else pass_cnt++;
    repeat (40) step(1'b0, 32'h0);
    chk_cnt++; if (pair_q.size() <= n0 || pair_q[n0].apc !== 32'h300)
      $display("FAIL rand_target: got n=%0d want first pc 300", pair_q.size() - n0); else pass_cnt++;
    foreach (pair_q[i]) begin
      chk_cnt++;
      if (pair_q[i].unexp || {pair_q[i].apc, pair_q[i].adata, pair_q[i].apc4} !== {pair_q[i].epc, pair_q[i].edata, pair_q[i].epc + 32'd4})
        $display("FAIL rand_stream[%0d]: got pc=%h instr=%h pc4=%h want pc=%h instr=%h", i, pair_q[i].apc, pair_q[i].adata, pair_q[i].apc4, pair_q[i].epc, pair_q[i].edata);
      else begin pass_cnt++; $display("random  consume pc=%h instr=%h", pair_q[i].apc, pair_q[i].adata); end
    end
  endtask

  task automatic test_wrap();
    int n0;
    do_reset();
    step(1'b1, 32'hFFFF_FFFC);
    req_log.delete();
    n0 = pair_q.size();
    repeat (12) step(1'b0, 32'h0);
    chk_cnt++; if (req_log.size() < 2 || req_log[0] !== 32'hFFFF_FFFC || req_log[1] !== 32'h0)
      $display("FAIL wrap_addr: got n=%0d want FFFFFFFC then 00000000", req_log.size()); else pass_cnt++;
    chk_cnt++; if (pair_q.size() <= n0 || pair_q[n0].apc4 !== 32'h0)
      $display("FAIL wrap_pc4: got n=%0d want pc4 0", pair_q.size() - n0); else pass_cnt++;
    foreach (pair_q[i]) begin
      chk_cnt++;
      if (pair_q[i].unexp || {pair_q[i].apc, pair_q[i].adata, pair_q[i].apc4} !== {pair_q[i].epc, pair_q[i].edata, pair_q[i].epc + 32'd4})
        $display("FAIL wrap_stream[%0d]: got pc=%h instr=%h pc4=%h want pc=%h instr=%h", i, pair_q[i].apc, pair_q[i].adata, pair_q[i].apc4, pair_q[i].epc, pair_q[i].edata);
      else begin pass_cnt++; $display("wrap    consume pc=%h instr=%h", pair_q[i].apc, pair_q[i].adata); end
    end
  endtask

  task automatic test_align();
    int n0;
    do_reset();
    step(1'b1, 32'h202);
    req_log.delete();
    n0 = pair_q.size();
`ifdef FETCH_ALIGN_CHECK_EN
    repeat (5) step(1'b0, 32'h0);
    chk_cnt++; if (fetch_fault !== 1'b1) $display("FAIL align_fault_set: got %b want 1", fetch_fault); else pass_cnt++;
    chk_cnt++; if (req_log.size() != 0 || instr_valid !== 1'b0)
      $display("FAIL align_halt: got reqs=%0d valid=%b want 0/0", req_log.size(), instr_valid); else pass_cnt++;
    step(1'b1, 32'h300);
    n0 = pair_q.size();
    step(1'b0, 32'h0);
    chk_cnt++; if (fetch_fault !== 1'b0) $display("FAIL align_fault_clr: got %b want 0", fetch_fault); else pass_cnt++;
    chk_cnt++; if (req_log.size() == 0 || req_log[0] !== 32'h300)
      $display("FAIL align_resume: got n=%0d want addr 300", req_log.size()); else pass_cnt++;
    repeat (8) step(1'b0, 32'h0);
`else
    repeat (8) step(1'b0, 32'h0);
    chk_cnt++; if (fetch_fault !== 1'b0) $display("FAIL align_fault_tied: got %b want 0", fetch_fault); else pass_cnt++;
    chk_cnt++; if (req_log.size() == 0 || req_log[0] !== 32'h200)
      $display("FAIL align_forced: got n=%0d want addr 200", req_log.size()); else pass_cnt++;
    chk_cnt++; if (pair_q.size() <= n0 || pair_q[n0].apc !== 32'h200)
      $display("FAIL align_first_pc: got n=%0d want pc 200", pair_q.size() - n0); else pass_cnt++;
`endif
    foreach (pair_q[i]) begin
      chk_cnt++;
      if (pair_q[i].unexp || {pair_q[i].apc, pair_q[i].adata, pair_q[i].apc4} !== {pair_q[i].epc, pair_q[i].edata, pair_q[i].epc + 32'd4})
        $display("FAIL align_stream[%0d]: got pc=%h instr=%h pc4=%h want pc=%h instr=%h", i, pair_q[i].apc, pair_q[i].adata, pair_q[i].apc4, pair_q[i].epc, pair_q[i].edata);
      else begin pass_cnt++; $display("align   consume pc=%h instr=%h", pair_q[i].apc, pair_q[i].adata); end
    end
  endtask

  initial begin
    chk_cnt = 0; pass_cnt = 0; cyc = 0;
    auto_pc = 32'h0;
    assert_reset();
    test_reset();
    test_stall();
    test_redirect();
    test_random();
    test_wrap();
    test_align();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", pass_cnt, chk_cnt);
    $fatal(1, "watchdog");
  end

endmodule
